// File: rtl/neuron_mac_q88_if.sv
// neuron_mac_q88_if
//   Handshake bundle between the weight/activation buffers, the MAC neuron
//   and the downstream sigmoid stage.
//
//   in_valid / in_ready        : beat handshake (activation, weight, bias)
//   in_data / in_weight        : signed Q8.8 activation and weight
//   in_bias                    : signed Q8.8 bias, used on the first beat only
//   out_valid / out_ready      : result handshake
//   out_data                   : signed Q8.8 saturated pre-activation
//   out_sat                    : out_data was clipped
//
//   master : the side that feeds beats and consumes results
//   slave  : the neuron itself
interface neuron_mac_q88_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] in_weight;
    logic [DATA_WIDTH-1:0] in_bias;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sat;

    modport master (
        output in_valid, in_data, in_weight, in_bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_weight, in_bias, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/neuron_mac_q88.sv
// neuron_mac_q88
//   Streaming multiply-accumulate neuron. Accepts N_INPUTS signed Q8.8
//   activation/weight beats plus a Q8.8 bias (taken from the first beat),
//   accumulates the dot product in an ACC_WIDTH accumulator, rounds half-up
//   back to Q8.8 and saturates. The result feeds the sigmoid stage directly.
//
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : neuron_mac_q88_if.slave (in_* beat handshake, out_* result
//           handshake, out_sat clip flag)
module neuron_mac_q88 #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int N_INPUTS    = 16,
    parameter int ACC_WIDTH   = 40
) (
    input logic              clk,
    input logic              reset,
    neuron_mac_q88_if.slave  bus
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int CNT_WIDTH  = $clog2(N_INPUTS + 1);
    localparam int RND_WIDTH  = ACC_WIDTH - FRACT_WIDTH;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ACCUM = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] ROUND = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;

    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(N_INPUTS - 1);

    // Half an LSB of the Q8.8 result, expressed in accumulator units.
    localparam logic signed [ACC_WIDTH-1:0] HALF_LSB =
        {{(ACC_WIDTH - FRACT_WIDTH + 1){1'b0}}, 1'b1, {(FRACT_WIDTH - 1){1'b0}}};

    localparam logic signed [RND_WIDTH-1:0] MAX_R =
        {{(RND_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [RND_WIDTH-1:0] MIN_R =
        {{(RND_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    localparam logic [DATA_WIDTH-1:0] MAX_D = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_D = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    logic [2:0]                    state;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [PROD_WIDTH-1:0]  prod;
    logic                          prod_valid;
    logic [CNT_WIDTH-1:0]          count;
    logic signed [RND_WIDTH-1:0]   rnd_q;
    logic                          round_pending;
    logic [DATA_WIDTH-1:0]         out_data_q;
    logic                          out_sat_q;
    logic                          out_valid_q;

    logic                          accepting;
    logic                          beat;
    logic signed [DATA_WIDTH-1:0]  data_s;
    logic signed [DATA_WIDTH-1:0]  weight_s;
    logic signed [DATA_WIDTH-1:0]  bias_s;
    logic signed [PROD_WIDTH-1:0]  prod_next;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   bias_ext;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic signed [ACC_WIDTH-1:0]   acc_rounded;
    logic signed [RND_WIDTH-1:0]   rnd_next;
    logic [DATA_WIDTH-1:0]         sat_data;
    logic                          sat_flag;

    // in_ready is gated by the reset pin so it reads 0 while reset is held
    // and rises in the first cycle after release.
    assign accepting   = ((state == IDLE) || (state == ACCUM)) && reset;
    assign beat        = bus.in_valid && accepting;

    assign data_s      = bus.in_data;
    assign weight_s    = bus.in_weight;
    assign bias_s      = bus.in_bias;
    assign prod_next   = data_s * weight_s;

    assign prod_ext    = {{(ACC_WIDTH - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    assign bias_ext    = {{(ACC_WIDTH - DATA_WIDTH - FRACT_WIDTH){bias_s[DATA_WIDTH-1]}},
                          bias_s, {FRACT_WIDTH{1'b0}}};
    assign acc_sum     = acc + prod_ext;

    // Round half up: add half an LSB, then an arithmetic shift floors.
    assign acc_rounded = acc + HALF_LSB;
    assign rnd_next    = RND_WIDTH'(acc_rounded >>> FRACT_WIDTH);

    // Clamp the registered rounded value into the Q8.8 range.
    always_comb begin
        sat_data = rnd_q[DATA_WIDTH-1:0];
        sat_flag = 1'b0;
        if (rnd_q > MAX_R) begin
            sat_data = MAX_D;
            sat_flag = 1'b1;
        end else if (rnd_q < MIN_R) begin
            sat_data = MIN_D;
            sat_flag = 1'b1;
        end
    end

    // Main sequencer. Products are registered one cycle before being added so
    // the multiplier and the wide adder sit in separate stages; DRAIN folds in
    // the final product. ROUND spends two cycles: the wide rounding add is
    // registered first, then the clamp compare produces the output, which
    // keeps the 40-bit carry chain off the saturation path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            acc           <= '0;
            prod          <= '0;
            prod_valid    <= 1'b0;
            count         <= '0;
            rnd_q         <= '0;
            round_pending <= 1'b0;
            out_data_q    <= '0;
            out_sat_q     <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        acc        <= bias_ext;
                        prod       <= prod_next;
                        prod_valid <= 1'b1;
                        count      <= CNT_WIDTH'(1);
                        state      <= (N_INPUTS == 1) ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc <= acc_sum;
                    end
                    if (beat) begin
                        prod       <= prod_next;
                        prod_valid <= 1'b1;
                        count      <= count + CNT_WIDTH'(1);
                        if (count == LAST_COUNT) begin
                            state <= DRAIN;
                        end
                    end else begin
                        prod_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (prod_valid) begin
                        acc <= acc_sum;
                    end
                    prod_valid    <= 1'b0;
                    round_pending <= 1'b0;
                    state         <= ROUND;
                end
                ROUND: begin
                    if (!round_pending) begin
                        rnd_q         <= rnd_next;
                        round_pending <= 1'b1;
                    end else begin
                        out_data_q    <= sat_data;
                        out_sat_q     <= sat_flag;
                        out_valid_q   <= 1'b1;
                        round_pending <= 1'b0;
                        state         <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        acc         <= '0;
                        count       <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = accepting;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_mac_q88.sv
// tb_neuron_mac_q88
//   Directed self-checking bench for neuron_mac_q88 with N_INPUTS=4.
//   Inputs change 1 time unit after the rising edge; outputs are sampled at
//   the same point, well away from the active edge.
module tb_neuron_mac_q88;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    neuron_mac_q88_if #(.DATA_WIDTH(16)) bus ();

    neuron_mac_q88 #(
        .DATA_WIDTH (16),
        .FRACT_WIDTH(8),
        .N_INPUTS   (4),
        .ACC_WIDTH  (40)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 unit past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one clock edge.
    task automatic applyStimulus(input logic [15:0] data, input logic [15:0] weight,
                                 input logic [15:0] bias);
        bus.in_valid  = 1'b1;
        bus.in_data   = data;
        bus.in_weight = weight;
        bus.in_bias   = bias;
        step();
        bus.in_valid  = 1'b0;
    endtask

    // Four back-to-back beats: the first one distinct, the other three equal.
    // Non-first beats carry a junk bias that must be ignored.
    task automatic sendVector(input logic [15:0] bias,
                              input logic [15:0] first_data, input logic [15:0] first_weight,
                              input logic [15:0] rest_data, input logic [15:0] rest_weight);
        applyStimulus(first_data, first_weight, bias);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(rest_data, rest_weight, 16'h5A5A);
        end
    endtask

    // Called just after the last-beat edge k with out_ready high: checks the
    // k+3 latency, the result, and the handshake at edge k+4.
    task automatic expectResult(input string tag, input logic [15:0] exp_data,
                                input logic exp_sat);
        checkOutput({tag, " in_ready after last beat"}, 32'(bus.in_ready), 32'd0);
        step();
        step();
        checkOutput({tag, " out_valid at k+2"}, 32'(bus.out_valid), 32'd0);
        step();
        checkOutput({tag, " out_valid at k+3"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, " out_data"}, 32'(bus.out_data), 32'(exp_data));
        checkOutput({tag, " out_sat"}, 32'(bus.out_sat), 32'(exp_sat));
        step();
        checkOutput({tag, " out_valid after take"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, " in_ready after take"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Directed sequence.
    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_weight = '0;
        bus.in_bias   = '0;
        bus.out_ready = 1'b1;

        step();
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset out_data", 32'(bus.out_data), 32'd0);
        checkOutput("reset out_sat", 32'(bus.out_sat), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("release in_ready", 32'(bus.in_ready), 32'd1);

        // 1.0 * 0.5 four times = 2.0
        sendVector(16'h0000, 16'h0100, 16'h0080, 16'h0100, 16'h0080);
        expectResult("basic", 16'h0200, 1'b0);

        // 0.5 + 4 * (-1.0 * 1.0) = -3.5
        sendVector(16'h0080, 16'hFF00, 16'h0100, 16'hFF00, 16'h0100);
        expectResult("negative", 16'hFC80, 1'b0);

        // Exactly half an LSB rounds up, just under half rounds down.
        sendVector(16'h0000, 16'h0001, 16'h0080, 16'h0000, 16'h0000);
        expectResult("round up", 16'h0001, 1'b0);
        sendVector(16'h0000, 16'h0001, 16'h007F, 16'h0000, 16'h0000);
        expectResult("round down", 16'h0000, 1'b0);

        // Saturation in both directions.
        sendVector(16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        expectResult("sat pos", 16'h7FFF, 1'b1);
        sendVector(16'h0000, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF);
        expectResult("sat neg", 16'h8000, 1'b1);

        // Gapped input and held-off output: 1.0 + 4 * (2.0 * 0.25) = 3.0
        bus.out_ready = 1'b0;
        applyStimulus(16'h0200, 16'h0040, 16'h0100);
        step();
        applyStimulus(16'h0200, 16'h0040, 16'h7FFF);
        step();
        applyStimulus(16'h0200, 16'h0040, 16'h8000);
        step();
        applyStimulus(16'h0200, 16'h0040, 16'h1234);
        step();
        step();
        step();
        checkOutput("gap out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("gap out_data", 32'(bus.out_data), 32'h0300);
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h7FFF;
        bus.in_weight = 16'h7FFF;
        bus.in_bias   = 16'h7FFF;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("hold%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("hold%0d out_data", i), 32'(bus.out_data), 32'h0300);
            checkOutput($sformatf("hold%0d in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        checkOutput("gap out_valid after take", 32'(bus.out_valid), 32'd0);
        checkOutput("gap in_ready after take", 32'(bus.in_ready), 32'd1);
        sendVector(16'h0000, 16'h0100, 16'h0080, 16'h0100, 16'h0080);
        expectResult("after gap", 16'h0200, 1'b0);

        // Abort a vector after two beats with reset, then run a clean one.
        applyStimulus(16'h7FFF, 16'h7FFF, 16'h7FFF);
        applyStimulus(16'h7FFF, 16'h7FFF, 16'h7FFF);
        reset = 1'b0;
        #1;
        checkOutput("abort in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("abort out_valid", 32'(bus.out_valid), 32'd0);
        step();
        reset = 1'b1;
        #1;
        checkOutput("abort release in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("abort release out_valid", 32'(bus.out_valid), 32'd0);
        sendVector(16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        expectResult("fresh", 16'h0400, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_mac_q88.md
Name: neuron_mac_q88

Overview:
- Streaming multiply-accumulate neuron: takes N_INPUTS signed Q8.8 activation/weight pairs plus one Q8.8 bias, forms the dot product with a wide accumulator, rounds and saturates back to Q8.8.
- Sits directly upstream of the Q8.8 sigmoid activation stage; out_data feeds the sigmoid X input unchanged.
- Valid/ready handshake on both sides, so it drops into the layer pipeline between the weight/activation buffers and the activation function.

Parameters:
- DATA_WIDTH, 16, width of activations, weights, bias and result (signed two's complement).
- FRACT_WIDTH, 8, fractional bits of every DATA_WIDTH operand (Q8.8).
- N_INPUTS, 16, beats per dot product, range 1..256.
- ACC_WIDTH, 40, accumulator width; must be at least 2*DATA_WIDTH + clog2(N_INPUTS) + 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_weight/in_bias valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  DATA_WIDTH  signed Q8.8 activation.
- in_weight  input  DATA_WIDTH  signed Q8.8 weight.
- in_bias  input  DATA_WIDTH  signed Q8.8 bias; sampled only on the first beat of a vector.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATA_WIDTH  signed Q8.8 saturated pre-activation.
- out_sat  output  1  out_data was clipped, qualified by out_valid.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, in_ready=0 while reset is asserted and 1 in the first cycle after release. out_valid=0, out_data=0, out_sat=0, accumulator=0, beat counter=0, product-valid=0.
- Beat accept: in_valid & in_ready at a rising edge.
- FSM states:
  - IDLE: in_ready=1. First accepted beat loads accumulator with sign-extended in_bias << FRACT_WIDTH, registers the product in_data*in_weight (full 2*DATA_WIDTH signed), and sets counter=1. Goes to ACCUM, or to DRAIN if N_INPUTS=1.
  - ACCUM: in_ready=1. Each accepted beat registers its product and increments the counter. Every cycle with product-valid=1 adds the sign-extended product to the accumulator. The beat that makes counter=N_INPUTS goes to DRAIN. Idle cycles (in_valid=0) are legal and hold state.
  - DRAIN: in_ready=0; absorbs the last product into the accumulator; goes to ROUND.
  - ROUND: in_ready=0.
    - r = (acc + 2^(FRACT_WIDTH-1)) >>> FRACT_WIDTH (round half up).
    - If r > 2^(DATA_WIDTH-1)-1, out_data = 0x7FFF; if r < -2^(DATA_WIDTH-1), out_data = 0x8000; otherwise out_data = r[DATA_WIDTH-1:0].
    - out_sat=1 iff clipped. Registers out_data and out_sat, sets out_valid=1, goes to OUT.
  - OUT: in_ready=0. out_data, out_sat and out_valid are held stable until out_ready=1. On that edge: out_valid=0, accumulator and counter cleared, return to IDLE.
- Latency: last beat accepted at edge k → out_valid=1 after edge k+3. Minimum vector period is N_INPUTS+4 cycles with out_ready held high.
- No new vector is accepted before the result is taken (in_ready=0 in DRAIN/ROUND/OUT); there is no overlap between vectors.
- in_bias on non-first beats is ignored.
- The accumulator never wraps within the ACC_WIDTH rule; saturation applies only at the output.
- Reset asserted mid-vector or while out_valid=1 discards all partial state immediately; the result is lost and out_valid drops without a handshake.

Test Plan:
- N_INPUTS=4, bias=0x0000, four beats in_data=0x0100, in_weight=0x0080 → out_data=0x0200, out_sat=0; out_valid rises 3 edges after the 4th beat.
- N_INPUTS=4, bias=0x0080, four beats in_data=0xFF00, in_weight=0x0100 → out_data=0xFC80 (-3.5), out_sat=0.
- Rounding: N_INPUTS=4, bias=0, beat0 in_data=0x0001, in_weight=0x0080, other beats zero → out_data=0x0001; same with in_weight=0x007F → 0x0000.
- Saturation: N_INPUTS=4, four beats 0x7FFF×0x7FFF → out_data=0x7FFF, out_sat=1; four beats 0x8000×0x7FFF → 0x8000, out_sat=1.
- Backpressure and gaps: in_valid toggled 1/0 across the vector; out_ready held low 5 cycles after out_valid. out_data must stay stable and in_ready=0 throughout; the result is correct; the next vector is accepted the cycle after the out handshake.
- Reset after beat 2 of 4 → out_valid=0, in_ready=1 after release. A fresh 4-beat vector (0x0100×0x0100, bias 0) → 0x0400, with no residue from the aborted vector.
